// File: rtl/csr_ctrl_pkg.sv
// Shared constants for the machine-mode CSR controller: CSR addresses,
// mstatus bit positions and FSM state encodings.
package csr_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_T_EPC    = 3'd1;
  localparam logic [2:0] ST_T_CAUSE  = 3'd2;
  localparam logic [2:0] ST_T_STATUS = 3'd3;
  localparam logic [2:0] ST_M_STATUS = 3'd4;
  localparam logic [2:0] ST_REDIR    = 3'd5;

endpackage

// File: rtl/csr_regfile.sv
// CSR storage with a single write port, combinational read mux and the
// free-running mcycle counter. Unimplemented addresses read 0, writes dropped.
module csr_regfile
  import csr_ctrl_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     raddr,
  output logic [XLEN-1:0] rdata,
  input  logic            we,
  input  logic [11:0]     waddr,
  input  logic [XLEN-1:0] wdata,
  output logic            mie,
  output logic            mpie,
  output logic [XLEN-1:0] mtvec,
  output logic [XLEN-1:0] mepc
);

  localparam logic [XLEN-1:0] ONE = 1;

  logic [XLEN-1:0] mscratch;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mcycle;
  logic [XLEN-1:0] mstatus_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= RESET_MTVEC;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
    end else if (we) begin
      case (waddr)
        CSR_MSTATUS: begin
          mie  <= wdata[MIE_BIT];
          mpie <= wdata[MPIE_BIT];
        end
        CSR_MTVEC:    mtvec    <= {wdata[XLEN-1:2], 2'b00};
        CSR_MSCRATCH: mscratch <= wdata;
        CSR_MEPC:     mepc     <= {wdata[XLEN-1:2], 2'b00};
        CSR_MCAUSE:   mcause   <= wdata;
        default: ;
      endcase
    end
  end

  // A write to mcycle wins over the increment in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle <= '0;
    end else if (we && (waddr == CSR_MCYCLE)) begin
      mcycle <= wdata;
    end else begin
      mcycle <= mcycle + ONE;
    end
  end

  always_comb begin
    mstatus_val           = '0;
    mstatus_val[MIE_BIT]  = mie;
    mstatus_val[MPIE_BIT] = mpie;
  end

  always_comb begin
    rdata = '0;
    case (raddr)
      CSR_MSTATUS:  rdata = mstatus_val;
      CSR_MTVEC:    rdata = mtvec;
      CSR_MSCRATCH: rdata = mscratch;
      CSR_MEPC:     rdata = mepc;
      CSR_MCAUSE:   rdata = mcause;
      CSR_MCYCLE:   rdata = mcycle;
      default:      rdata = '0;
    endcase
  end

endmodule

// File: rtl/csr_ctrl.sv
// Machine-mode CSR controller: arbitrates the single CSR write port between
// the pipeline, the trap-entry sequence and the mret sequence.
module csr_ctrl
  import csr_ctrl_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_raddr,
  output logic [XLEN-1:0] csr_rdata,
  input  logic            csr_we,
  input  logic [11:0]     csrw_addr,
  input  logic [XLEN-1:0] csrw_data,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret_req,
  output logic            stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [2:0]      fsm_state
);

  // Handshake: trap_req/mret_req are level requests held by the requester
  // until redirect_valid; they are only accepted in IDLE and must drop
  // before the first IDLE cycle following REDIR.
  logic [2:0]      state;
  logic            redir_tgt_is_mepc;
  logic [XLEN-1:0] pc_lat;
  logic [XLEN-1:0] cause_lat;

  logic            rf_we;
  logic [11:0]     rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            mie;
  logic            mpie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;

  csr_regfile #(
    .XLEN        (XLEN),
    .RESET_MTVEC (RESET_MTVEC)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .raddr (csr_raddr),
    .rdata (csr_rdata),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .mie   (mie),
    .mpie  (mpie),
    .mtvec (mtvec),
    .mepc  (mepc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      redir_tgt_is_mepc <= 1'b0;
      pc_lat            <= '0;
      cause_lat         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trap_req) begin
            pc_lat            <= trap_pc;
            cause_lat         <= trap_cause;
            redir_tgt_is_mepc <= 1'b0;
            state             <= ST_T_EPC;
          end else if (mret_req) begin
            redir_tgt_is_mepc <= 1'b1;
            state             <= ST_M_STATUS;
          end
        end
        ST_T_EPC:    state <= ST_T_CAUSE;
        ST_T_CAUSE:  state <= ST_T_STATUS;
        ST_T_STATUS: state <= ST_REDIR;
        ST_M_STATUS: state <= ST_REDIR;
        ST_REDIR:    state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  // Write-port source is chosen by state; a pipeline write that coincides
  // with an accepted trap or mret belongs to a squashed instruction.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    case (state)
      ST_IDLE: begin
        if (csr_we && !trap_req && !mret_req) begin
          rf_we    = 1'b1;
          rf_waddr = csrw_addr;
          rf_wdata = csrw_data;
        end
      end
      ST_T_EPC: begin
        rf_we    = 1'b1;
        rf_waddr = CSR_MEPC;
        rf_wdata = pc_lat;
      end
      ST_T_CAUSE: begin
        rf_we    = 1'b1;
        rf_waddr = CSR_MCAUSE;
        rf_wdata = cause_lat;
      end
      ST_T_STATUS: begin
        rf_we              = 1'b1;
        rf_waddr           = CSR_MSTATUS;
        rf_wdata[MPIE_BIT] = mie;
      end
      ST_M_STATUS: begin
        rf_we              = 1'b1;
        rf_waddr           = CSR_MSTATUS;
        rf_wdata[MIE_BIT]  = mpie;
        rf_wdata[MPIE_BIT] = 1'b1;
      end
      default: ;
    endcase
  end

  assign stall          = (state != ST_IDLE);
  assign redirect_valid = (state == ST_REDIR);
  assign redirect_pc    = redirect_valid ? (redir_tgt_is_mepc ? mepc : mtvec) : '0;
  assign fsm_state      = state;

endmodule

// File: tb/tb_csr_ctrl.sv
// Self-checking bench for csr_ctrl: directed scenarios followed by random
// operations, checked against a transaction-level CSR model.
module tb_csr_ctrl;
  import csr_ctrl_pkg::*;

  localparam int          XLEN        = 32;
  localparam logic [31:0] RESET_MTVEC = 32'h0;

  logic        clk;
  logic        rst;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_we;
  logic [11:0] csrw_addr;
  logic [31:0] csrw_data;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic        mret_req;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [2:0]  fsm_state;

  csr_ctrl #(.XLEN(XLEN), .RESET_MTVEC(RESET_MTVEC)) dut (
    .clk            (clk),
    .rst            (rst),
    .csr_raddr      (csr_raddr),
    .csr_rdata      (csr_rdata),
    .csr_we         (csr_we),
    .csrw_addr      (csrw_addr),
    .csrw_data      (csrw_data),
    .trap_req       (trap_req),
    .trap_cause     (trap_cause),
    .trap_pc        (trap_pc),
    .mret_req       (mret_req),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fsm_state      (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mcycle;
  logic [31:0] exp_q[$];
  logic [11:0] addr_tab[8] = '{12'h300, 12'h305, 12'h340, 12'h341,
                               12'h342, 12'hB00, 12'h7C0, 12'h301};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model
  task automatic model_reset();
    m_mstatus  = 32'h0;
    m_mtvec    = RESET_MTVEC;
    m_mscratch = 32'h0;
    m_mepc     = 32'h0;
    m_mcause   = 32'h0;
    m_mcycle   = 32'h0;
  endtask

  function automatic logic [31:0] ref_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hB00: return m_mcycle;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [31:0] d);
    case (a)
      12'h300: m_mstatus  = d & 32'h0000_0088;
      12'h305: m_mtvec    = d & 32'hFFFF_FFFC;
      12'h340: m_mscratch = d;
      12'h341: m_mepc     = d & 32'hFFFF_FFFC;
      12'h342: m_mcause   = d;
      12'hB00: m_mcycle   = d;
      default: ;
    endcase
  endtask

  // one clock edge; the model's cycle counter advances with it
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else m_mcycle = m_mcycle + 32'd1;
    #1;
  endtask

  // driver tasks
  task automatic pipe_write(input logic [11:0] a, input logic [31:0] d);
    csr_we    = 1'b1;
    csrw_addr = a;
    csrw_data = d;
    csr_raddr = a;
    @(negedge clk);
    chk("wr_cycle_old", csr_rdata, ref_read(a));
    tick();
    model_write(a, d);
    csr_we = 1'b0;
  endtask

  task automatic rd_chk(input logic [11:0] a, input string tag);
    csr_raddr = a;
    @(negedge clk);
    chk(tag, csr_rdata, ref_read(a));
    tick();
  endtask

  task automatic run_seq(input bit is_trap, input logic [31:0] pc, input logic [31:0] cause,
                         input bit with_we, input logic [31:0] we_data, input bit noise);
    int n_stall;
    int n_redir;
    bit done;
    int exp_stall;
    exp_q.push_back(is_trap ? m_mtvec : m_mepc);
    exp_stall = is_trap ? 4 : 2;
    trap_req   = is_trap;
    mret_req   = !is_trap;
    trap_pc    = pc;
    trap_cause = cause;
    if (with_we) begin
      csr_we    = 1'b1;
      csrw_addr = 12'h340;
      csrw_data = we_data;
    end
    @(negedge clk);
    chk("accept_stall", {31'b0, stall}, 32'h0);
    tick();
    csr_we  = 1'b0;
    n_stall = 0;
    n_redir = 0;
    done    = 1'b0;
    for (int c = 0; c < 12 && !done; c++) begin
      // pipeline writes while stalled must be ignored
      if (noise && stall) begin
        csr_we    = 1'($urandom_range(0, 1));
        csrw_addr = addr_tab[$urandom_range(0, 7)];
        csrw_data = $urandom;
      end else begin
        csr_we = 1'b0;
      end
      @(negedge clk);
      if (stall) n_stall++;
      if (redirect_valid) begin
        n_redir++;
        if (exp_q.size() > 0) chk("redirect_pc", redirect_pc, exp_q.pop_front());
        else chk("redirect_extra", redirect_pc, 32'hFFFF_FFFF);
        trap_req = 1'b0;
        mret_req = 1'b0;
      end else begin
        chk("redirect_pc_zero", redirect_pc, 32'h0);
      end
      if (!stall) done = 1'b1;
      tick();
    end
    csr_we   = 1'b0;
    trap_req = 1'b0;
    mret_req = 1'b0;
    chk("done_in_budget", {31'b0, done}, 32'h1);
    chk("stall_cycles", n_stall, exp_stall);
    chk("redirect_cycles", n_redir, 32'd1);
    exp_q.delete();
    if (is_trap) begin
      m_mepc    = pc & 32'hFFFF_FFFC;
      m_mcause  = cause;
      m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
    end else begin
      m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 6; i++) rd_chk(addr_tab[i], tag);
  endtask

  initial begin
    rst = 1'b1; csr_raddr = '0; csr_we = 1'b0; csrw_addr = '0; csrw_data = '0;
    trap_req = 1'b0; trap_cause = '0; trap_pc = '0; mret_req = 1'b0;
    model_reset();
    tick();
    tick();
    @(negedge clk);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_redirect_valid", {31'b0, redirect_valid}, 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    rst = 1'b0;
    tick();
    check_all("reset_value");

    pipe_write(12'h305, 32'h8000_0103);
    rd_chk(12'h305, "mtvec_mask");
    chk("mtvec_const", m_mtvec, 32'h8000_0100);
    pipe_write(12'h7C0, 32'h1);
    rd_chk(12'h7C0, "unimpl_read");

    pipe_write(12'h300, 32'h8);
    pipe_write(12'h305, 32'h100);
    run_seq(1'b1, 32'h44, 32'hB, 1'b0, 32'h0, 1'b0);
    rd_chk(12'h341, "trap_mepc");
    rd_chk(12'h342, "trap_mcause");
    rd_chk(12'h300, "trap_mstatus");

    run_seq(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    rd_chk(12'h300, "mret_mstatus");

    run_seq(1'b1, 32'h80, 32'h2, 1'b1, 32'h0000_DEAD, 1'b0);
    rd_chk(12'h340, "squash_mscratch");
    check_all("after_squash");

    // reset during T_CAUSE aborts the trap
    trap_req = 1'b1; trap_pc = 32'h1234; trap_cause = 32'h5;
    tick();
    tick();
    @(negedge clk);
    chk("pre_abort_stall", {31'b0, stall}, 32'h1);
    rst = 1'b1;
    trap_req = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_redirect", {31'b0, redirect_valid}, 32'h0);
      chk("abort_no_stall", {31'b0, stall}, 32'h0);
      tick();
    end
    check_all("abort_reset_value");

    pipe_write(12'hB00, 32'hFFFF_FFFF);
    tick();
    rd_chk(12'hB00, "mcycle_wrap0");
    rd_chk(12'hB00, "mcycle_wrap1");

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: pipe_write(addr_tab[$urandom_range(0, 7)], $urandom);
        1: rd_chk(addr_tab[$urandom_range(0, 7)], "rand_read");
        2: run_seq(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom, 1'b1);
        default: run_seq(1'b0, 32'h0, 32'h0, 1'($urandom_range(0, 1)), $urandom, 1'b1);
      endcase
    end
    check_all("final_state");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
